// File: rtl/pc_controller.sv
// Program counter and interrupt/exception entry controller for a single-cycle MIPS-style core.
// Define PC_CONTROLLER_EXCEPTION_EN to enable the undefined-instruction exception.
module pc_controller (
   input  logic        clk,
   input  logic        reset,
   input  logic        Stall,
   input  logic [1:0]  PCSrc,
   input  logic        BranchTaken,
   input  logic [31:0] BranchOffset,
   input  logic [25:0] JumpTarget,
   input  logic [31:0] RegTarget,
   input  logic        IRQ,
   input  logic        Undefined,
   output logic [31:0] PC,
   output logic [31:0] PCPlus4,
   output logic [31:0] EPC,
   output logic        EPCWrite,
   output logic        Squash,
   output logic        IrqAck,
   output logic        Kernel
);

   localparam logic [31:0] RESET_VECTOR = 32'h8000_0000;
   localparam logic [31:0] IRQ_VECTOR   = 32'h8000_0004;
`ifdef PC_CONTROLLER_EXCEPTION_EN
   localparam logic [31:0] EXC_VECTOR   = 32'h8000_0008;
`endif

   typedef enum logic {
      IRQ_IDLE,
      IRQ_PENDING
   } irqState_t;

   irqState_t   irqStateQ, irqStateD;
   logic [31:0] pcQ, pcD;
   logic [31:0] pcPlus4;
   logic [31:0] branchTarget;
   logic [31:0] jumpTarget;
   logic        kernel;
   logic        irqTaken;
   logic        excTaken;
   logic        kernelUndef;
   logic [2:0]  unusedOffsetBits;

   // Increments and branch offsets wrap inside bits 30:0; only jr may change the mode bit.
   assign kernel           = pcQ[31];
   assign pcPlus4          = {pcQ[31], pcQ[30:0] + 31'd4};
   assign branchTarget     = {pcQ[31], pcPlus4[30:0] + {BranchOffset[28:0], 2'b00}};
   assign jumpTarget       = {pcQ[31:28], JumpTarget, 2'b00};
   assign unusedOffsetBits = BranchOffset[31:29];

`ifdef PC_CONTROLLER_EXCEPTION_EN
   assign excTaken    = Undefined & ~kernel & ~Stall & ~reset;
   assign kernelUndef = Undefined &  kernel & ~Stall & ~reset;
`else
   logic unusedUndefined;
   assign unusedUndefined = Undefined;
   assign excTaken        = 1'b0;
   assign kernelUndef     = 1'b0;
`endif

   assign irqTaken = ((irqStateQ == IRQ_PENDING) | IRQ) & ~kernel & ~Stall & ~excTaken & ~reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         pcQ       <= RESET_VECTOR;
         irqStateQ <= IRQ_IDLE;
      end else begin
         pcQ       <= pcD;
         irqStateQ <= irqStateD;
      end
   end

   // Priority: exception > interrupt > stall > normal next-PC selection.
   always_comb begin
      pcD       = pcQ;
      irqStateD = irqStateQ;
      EPC       = pcQ;
      EPCWrite  = 1'b0;
      Squash    = 1'b0;
      IrqAck    = 1'b0;
      if (IRQ) begin
         irqStateD = IRQ_PENDING;
      end
`ifdef PC_CONTROLLER_EXCEPTION_EN
      if (excTaken) begin
         pcD      = EXC_VECTOR;
         EPC      = pcPlus4;
         EPCWrite = 1'b1;
         Squash   = 1'b1;
      end else
`endif
      if (irqTaken) begin
         pcD       = IRQ_VECTOR;
         EPC       = pcQ;
         EPCWrite  = 1'b1;
         Squash    = 1'b1;
         IrqAck    = 1'b1;
         irqStateD = IRQ_IDLE;
      end else if (Stall) begin
         pcD = pcQ;
      end else if (kernelUndef) begin
         pcD    = pcPlus4;
         Squash = 1'b1;
      end else begin
         case (PCSrc)
            2'd0:    pcD = pcPlus4;
            2'd1:    pcD = BranchTaken ? branchTarget : pcPlus4;
            2'd2:    pcD = jumpTarget;
            default: pcD = RegTarget;
         endcase
      end
   end

   assign PC      = pcQ;
   assign PCPlus4 = pcPlus4;
   assign Kernel  = kernel;

endmodule
